// File: rtl/ama_riscv_pkg.sv
// Shared definitions for the load path: funct3 load widths, FSM encoding and
// decode helpers for misaligned / unsupported widths.
package ama_riscv_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StResp = 2'd1,
    StHold = 2'd2
  } load_state_e;

  // Any funct3 that is not one of the five supported load widths.
  function automatic logic is_bad_width(input logic [2:0] width);
    return !(width == Funct3Lb  || width == Funct3Lh  || width == Funct3Lw ||
             width == Funct3Lbu || width == Funct3Lhu);
  endfunction

  // Halfword crossing the word boundary, or word not on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] offset, input logic [2:0] width);
    return ((width[1:0] == 2'b01) && (offset == 2'd3)) ||
           ((width[1:0] == 2'b10) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/ama_riscv_load_extract.sv
// Combinational byte/halfword/word extraction with sign or zero extension.
// Unsupported widths return zero; misaligned cases are suppressed by the caller.
module ama_riscv_load_extract
  import ama_riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  width,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed field, then extend it according to the width.
  always_comb begin
    byte_sel = 8'h00;
    unique case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase

    // Offset 3 is misaligned for halfwords; it aliases offset 2 and gets masked.
    half_sel = offset[1] ? rdata[31:16] : (offset[0] ? rdata[23:8] : rdata[15:0]);

    result = 32'h0;
    case (width)
      Funct3Lb:  result = {{24{byte_sel[7]}}, byte_sel};
      Funct3Lbu: result = {24'h0, byte_sel};
      Funct3Lh:  result = {{16{half_sel[15]}}, half_sel};
      Funct3Lhu: result = {16'h0, half_sel};
      Funct3Lw:  result = rdata;
      default:   result = 32'h0;
    endcase
  end

endmodule

// File: rtl/ama_riscv_load_align.sv
// Load alignment for a synchronous-read DMEM: captures load attributes at issue,
// aligns/extends the returned word one cycle later and holds it across stalls.
// Define AMA_RISCV_LOAD_MISALIGN_TRAP_EN to report misaligned loads as faults;
// otherwise they return valid zero data and ld_misaligned stays 0.
module ama_riscv_load_align
  import ama_riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_en,
  input  logic [1:0]  req_offset,
  input  logic [2:0]  req_width,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        ld_misaligned,
  output logic        ld_bad_width
);

  load_state_e state_q, state_d;

  logic [1:0]  offset_q;
  logic [2:0]  width_q;
  logic        mis_q;
  logic        bad_q;

  logic [31:0] hold_data_q;
  logic        hold_valid_q;
  logic        hold_mis_q;
  logic        hold_bad_q;

  logic        accept;
  logic        capture_hold;
  logic [31:0] ext_data;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_mis;
  logic        resp_bad;

  assign accept       = req_en && !stall && !flush;
  assign capture_hold = (state_q == StResp) && stall && !flush;

  ama_riscv_load_extract u_extract (
    .rdata  (dmem_rdata),
    .offset (offset_q),
    .width  (width_q),
    .result (ext_data)
  );

  // Response in the cycle after acceptance; bad width outranks misaligned.
  always_comb begin
    resp_bad  = bad_q;
    resp_data = (bad_q || mis_q) ? 32'h0 : ext_data;
`ifdef AMA_RISCV_LOAD_MISALIGN_TRAP_EN
    resp_mis   = mis_q && !bad_q;
    resp_valid = !bad_q && !mis_q;
`else
    resp_mis   = 1'b0;
    resp_valid = !bad_q;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = accept ? StResp : StIdle;
      StResp, StHold: begin
        if (flush)       state_d = StIdle;
        else if (stall)  state_d = StHold;
        else if (accept) state_d = StResp;
        else             state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register plus request attribute capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      offset_q <= 2'd0;
      width_q  <= 3'd0;
      mis_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        offset_q <= req_offset;
        width_q  <= req_width;
        mis_q    <= is_misaligned(req_offset, req_width);
        bad_q    <= is_bad_width(req_width);
      end
    end
  end

  // Freeze the live response when a stall first hits it, so later DMEM changes
  // cannot disturb the value presented to writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q  <= 32'h0;
      hold_valid_q <= 1'b0;
      hold_mis_q   <= 1'b0;
      hold_bad_q   <= 1'b0;
    end else if (capture_hold) begin
      hold_data_q  <= resp_data;
      hold_valid_q <= resp_valid;
      hold_mis_q   <= resp_mis;
      hold_bad_q   <= resp_bad;
    end
  end

  // Output mux by state; flush kills the flags in the same cycle.
  always_comb begin
    ld_data       = 32'h0;
    ld_valid      = 1'b0;
    ld_misaligned = 1'b0;
    ld_bad_width  = 1'b0;
    unique case (state_q)
      StResp: begin
        ld_data       = resp_data;
        ld_valid      = resp_valid;
        ld_misaligned = resp_mis;
        ld_bad_width  = resp_bad;
      end
      StHold: begin
        ld_data       = hold_data_q;
        ld_valid      = hold_valid_q;
        ld_misaligned = hold_mis_q;
        ld_bad_width  = hold_bad_q;
      end
      default: ;
    endcase
    if (flush) begin
      ld_valid      = 1'b0;
      ld_misaligned = 1'b0;
      ld_bad_width  = 1'b0;
    end
  end

endmodule

// File: doc/ama_riscv_load_align.md
# ama_riscv_load_align

Load-side counterpart to the DMEM store path. It captures load attributes (byte offset, width/signedness) when a load is issued to the synchronous-read DMEM. One cycle later it extracts, aligns and sign/zero-extends the returned word for the writeback stage. It holds the result across pipeline stalls, supports back-to-back loads, and flags misaligned or unsupported accesses.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_en`  in  1  load issued to DMEM this cycle.
- `req_offset`  in  2  byte offset, address bits [1:0].
- `req_width`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `stall`  in  1  pipeline hold; the block accepts no new request and holds its response.
- `flush`  in  1  kills any pending or held response and any request in the same cycle.
- `dmem_rdata`  in  32  DMEM read data, valid exactly one cycle after request acceptance.
- `ld_data`  out  32  aligned and extended load result.
- `ld_valid`  out  1  `ld_data` is valid this cycle.
- `ld_misaligned`  out  1  response-cycle pulse for a misaligned load.
- `ld_bad_width`  out  1  response-cycle pulse for funct3 011, 110 or 111.

## Operation
- **Acceptance:** a request is accepted when `req_en && !stall && !flush`. On acceptance the block registers offset, width, misalign flag and bad-width flag.
- **Misaligned condition:** halfword at offset 3, or word at offset != 0. This mirrors the store-mask rule.
- **Extraction (LB/LBU):** byte = `rdata[8*off +: 8]`.
- **Extraction (LH/LHU):** half = `rdata[8*off +: 16]`, for offset 0, 1 or 2.
- **Extraction (LW):** the full word.
- **Extension:** signed widths sign-extend from the top bit of the field; unsigned widths zero-extend.
- **Fault response:** `ld_valid`=0 and `ld_data`=0. Exactly one of `ld_misaligned` or `ld_bad_width` is 1. Bad width takes priority over misaligned.
- **FSM states:**
  - IDLE: no pending response.
  - RESP: response computed combinationally from `dmem_rdata`.
  - HOLD: response driven from the hold register.
- **IDLE:** on acceptance → RESP; otherwise stay.
- **RESP:**
  - flush → IDLE.
  - stall → capture the aligned result and flags into the hold register → HOLD.
  - acceptance → RESP (back-to-back).
  - otherwise → IDLE.
- **HOLD:**
  - flush → IDLE.
  - stall → stay.
  - `!stall`: the held output is consumed this cycle. Next state is RESP on acceptance, else IDLE.
- **Flush:** forces `ld_valid`, `ld_misaligned` and `ld_bad_width` to 0 combinationally in the flush cycle.

## Timing
- **Latency:** request accepted in cycle N → response in cycle N+1. Throughput is 1 load/cycle.
- **Outputs:** combinational from state and registers; they are valid only in RESP or HOLD.
- **Reset:**
  - state IDLE; all capture and hold registers 0.
  - `ld_data`=0, `ld_valid`=0, `ld_misaligned`=0, `ld_bad_width`=0.
  - A reset in RESP or HOLD drops the response immediately. No response follows reset release.
- **Stalled response:** a response presented during a stall stays on the outputs unchanged every stalled cycle. This holds even if `dmem_rdata` changes. The response is presented once more in the first non-stalled cycle.
- **Flush with request:** `req_en` together with `flush` is ignored.

## Configuration
- **With `AMA_RISCV_LOAD_MISALIGN_TRAP_EN` defined:** misaligned loads behave as in Operation.
- **Without it:**
  - `ld_misaligned` is tied to 0.
  - A misaligned load returns `ld_valid`=1 with `ld_data`=0, matching the store side's silent suppression.
  - `ld_bad_width` is unaffected.

## Structure
- **Shared package `ama_riscv_pkg`:**
  - funct3 load-width constants (LB, LH, LW, LBU, LHU).
  - FSM state encoding: IDLE, RESP, HOLD.
- **Sub-module `ama_riscv_load_extract`:** combinational; takes (`rdata`, offset, width) and returns the 32-bit result. It is instantiated once on the `dmem_rdata` path; the hold register stores its output.

## Test plan
1. LB, off 1, `rdata` 0x8899AABB → N+1: `ld_valid`=1, `ld_data`=0xFFFFFFAA. LBU same → 0x000000AA.
2. LH off 2 → 0xFFFF8899. LHU off 1 → 0x000099AA. LW off 0 → 0x8899AABB. Issue them back-to-back: three consecutive valid cycles.
3. LW off 2, width 011:
   - With the macro: misaligned pulse, `ld_valid`=0.
   - Without the macro: `ld_valid`=1, data 0.
   - Width 011: `ld_bad_width`=1, `ld_valid`=0.
4. LW off 0 at N, `stall` N+1..N+3, `rdata`→0 at N+2 → `ld_data`=0x8899AABB, valid N+1..N+4. A `req_en` during the stall is ignored.
5. Accept at N, `flush` at N+1 → `ld_valid`=0 in N+1, state IDLE. Separately, drop `rst_n` in HOLD → all outputs 0 immediately, nothing after release.
